// File: rtl/blackjack_pkg.sv
// Shared definitions for the blackjack dealer controller: state encoding,
// card code constants, default rule parameters and card/total helpers.
package blackjack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DEAL   = 3'd1,
    ST_PLAYER = 3'd2,
    ST_DEALER = 3'd3,
    ST_P_WIN  = 3'd4,
    ST_D_WIN  = 3'd5,
    ST_PUSH   = 3'd6,
    ST_P_BUST = 3'd7
  } state_t;

  localparam logic [3:0] CARD_ACE     = 4'd1;
  localparam logic [3:0] CARD_KING    = 4'd13;
  localparam logic [3:0] CARD_BLANK   = 4'd0;
  localparam logic [3:0] CARD_BAD_14  = 4'd14;
  localparam logic [3:0] CARD_BAD_15  = 4'd15;

  localparam int DEALER_STAND_DEFAULT = 17;
  localparam int MAX_CARDS_DEFAULT    = 7;

  localparam logic [4:0] BLACKJACK    = 5'd21;

  function automatic logic card_valid(input logic [3:0] code);
    return !(code == CARD_BLANK || code == CARD_BAD_14 || code == CARD_BAD_15);
  endfunction

  // Faces count 10; the ace counts 1 here and is promoted only via best_total.
  function automatic logic [4:0] card_points(input logic [3:0] code);
    if (code > 4'd10)
      return 5'd10;
    return {1'b0, code};
  endfunction

  function automatic logic [4:0] best_total(input logic [4:0] hard, input logic ace);
    if (ace && hard <= 5'd11)
      return hard + 5'd10;
    return hard;
  endfunction

endpackage

// File: rtl/blackjack_hand.sv
// One blackjack hand: hard sum, ace flag and card count, plus the best total
// now and the best total it would have if the presented card were added.
module blackjack_hand
  import blackjack_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       add,
  input  logic [3:0] card_code,
  output logic [4:0] best,
  output logic [4:0] best_add,
  output logic [2:0] count
);

  logic [4:0] hard_reg;
  logic       ace_reg;
  logic [2:0] count_reg;
  logic [4:0] points;
  logic       is_ace;

  assign points = card_points(card_code);
  assign is_ace = (card_code == CARD_ACE);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      hard_reg  <= 5'd0;
      ace_reg   <= 1'b0;
      count_reg <= 3'd0;
    end else if (add) begin
      hard_reg  <= hard_reg + points;
      ace_reg   <= ace_reg | is_ace;
      count_reg <= count_reg + 3'd1;
    end
  end

  assign best     = best_total(hard_reg, ace_reg);
  assign best_add = best_total(hard_reg + points, ace_reg | is_ace);
  assign count    = count_reg;

endmodule

// File: rtl/blackjack_dealer_ctrl.sv
// Blackjack round controller: deals, takes player hit/stand, plays the dealer
// hand to the stand threshold and resolves the outcome.
module blackjack_dealer_ctrl
  import blackjack_pkg::*;
#(
  parameter int DEALER_STAND = DEALER_STAND_DEFAULT,
  parameter int MAX_CARDS    = MAX_CARDS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       deal_pressed,
  input  logic       hit_pressed,
  input  logic       stand_pressed,
  input  logic [3:0] card_value,
  output logic [4:0] player_score,
  output logic [4:0] dealer_score,
  output logic [2:0] game_state,
  output logic       show_dealer_first,
  output logic [2:0] player_cards,
  output logic [2:0] dealer_cards
);

  localparam logic [4:0] STAND_L = 5'(DEALER_STAND);
  localparam logic [2:0] MAX_L   = 3'(MAX_CARDS);

  state_t     state_reg, state_next;
  logic [1:0] slot_reg, slot_next;
  logic       hit_pending_reg, hit_pending_next;
  logic [4:0] dealer_first_reg;

  logic       card_ok, hands_clear, player_add, dealer_add;
  logic       want_hit, hit_go, dealer_draw;
  logic [4:0] player_best, player_best_add, dealer_best, dealer_best_add_unused;
  logic [2:0] player_count, dealer_count;

  blackjack_hand u_player (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (hands_clear),
    .add       (player_add),
    .card_code (card_value),
    .best      (player_best),
    .best_add  (player_best_add),
    .count     (player_count)
  );

  blackjack_hand u_dealer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (hands_clear),
    .add       (dealer_add),
    .card_code (card_value),
    .best      (dealer_best),
    .best_add  (dealer_best_add_unused),
    .count     (dealer_count)
  );

  assign card_ok     = card_valid(card_value);
  // A hit that meets an invalid card stays pending so the draw retries next cycle.
  assign want_hit    = hit_pressed | hit_pending_reg;
  assign hit_go      = want_hit & ~stand_pressed & (player_count < MAX_L);
  assign dealer_draw = (dealer_best < STAND_L) & (dealer_count < MAX_L);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      slot_reg        <= 2'd0;
      hit_pending_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      slot_reg        <= slot_next;
      hit_pending_reg <= hit_pending_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    case (state_reg)
      ST_IDLE, ST_P_WIN, ST_D_WIN, ST_PUSH, ST_P_BUST: begin
        if (deal_pressed) begin
          state_next = ST_DEAL;
          slot_next  = 2'd0;
        end
      end
      ST_DEAL: begin
        if (card_ok) begin
          slot_next = slot_reg + 2'd1;
          // Player hand is complete before the last dealer slot is drawn.
          if (slot_reg == 2'd3)
            state_next = (player_best == BLACKJACK) ? ST_DEALER : ST_PLAYER;
        end
      end
      ST_PLAYER: begin
        if (stand_pressed)
          state_next = ST_DEALER;
        else if (player_add) begin
          if (player_best_add > BLACKJACK)
            state_next = ST_P_BUST;
          else if (player_best_add == BLACKJACK)
            state_next = ST_DEALER;
        end
      end
      ST_DEALER: begin
        if (!dealer_draw) begin
          if (dealer_best > BLACKJACK || player_best > dealer_best)
            state_next = ST_P_WIN;
          else if (player_best < dealer_best)
            state_next = ST_D_WIN;
          else
            state_next = ST_PUSH;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    hands_clear      = 1'b0;
    player_add       = 1'b0;
    dealer_add       = 1'b0;
    hit_pending_next = 1'b0;
    case (state_reg)
      ST_IDLE, ST_P_WIN, ST_D_WIN, ST_PUSH, ST_P_BUST: hands_clear = deal_pressed;
      ST_DEAL: begin
        player_add = card_ok & ~slot_reg[0];
        dealer_add = card_ok & slot_reg[0];
      end
      ST_PLAYER: begin
        player_add       = hit_go & card_ok;
        hit_pending_next = hit_go & ~card_ok;
      end
      ST_DEALER: dealer_add = dealer_draw & card_ok;
      default: ;
    endcase
  end

  // Face-up dealer card as shown while the hole card is hidden (ace as 11).
  always_ff @(posedge clk) begin
    if (!rst_n || hands_clear)
      dealer_first_reg <= 5'd0;
    else if (state_reg == ST_DEAL && slot_reg == 2'd1 && card_ok)
      dealer_first_reg <= (card_value == CARD_ACE) ? 5'd11 : card_points(card_value);
  end

  assign show_dealer_first = (state_reg == ST_DEAL) || (state_reg == ST_PLAYER);
  assign game_state        = state_reg;
  assign player_score      = player_best;
  assign dealer_score      = show_dealer_first ? dealer_first_reg : dealer_best;
  assign player_cards      = player_count;
  assign dealer_cards      = dealer_count;

endmodule

// File: tb/tb_blackjack_dealer_ctrl.sv
// Bench for blackjack_dealer_ctrl: directed rounds plus random play, checked
// each cycle against a card-list model of the game rules.
module tb_blackjack_dealer_ctrl;

  localparam int STAND = 17;
  localparam int MAXC  = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       deal_pressed = 1'b0;
  logic       hit_pressed = 1'b0;
  logic       stand_pressed = 1'b0;
  logic [3:0] card_value = 4'd0;
  logic [4:0] player_score, dealer_score;
  logic [2:0] game_state;
  logic       show_dealer_first;
  logic [2:0] player_cards, dealer_cards;

  always #5 clk = ~clk;

  blackjack_dealer_ctrl #(.DEALER_STAND(STAND), .MAX_CARDS(MAXC)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .deal_pressed      (deal_pressed),
    .hit_pressed       (hit_pressed),
    .stand_pressed     (stand_pressed),
    .card_value        (card_value),
    .player_score      (player_score),
    .dealer_score      (dealer_score),
    .game_state        (game_state),
    .show_dealer_first (show_dealer_first),
    .player_cards      (player_cards),
    .dealer_cards      (dealer_cards)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Model: hands as lists of card codes, states as the published game codes.
  int m_state = 0;
  int m_slot  = 0;
  bit m_pend  = 0;
  int p_hand[$];
  int d_hand[$];

  function automatic int pts(input int c);
    return (c >= 10) ? 10 : c;
  endfunction

  function automatic int best(input int h[$]);
    int s = 0;
    bit a = 0;
    foreach (h[i]) begin
      s += pts(h[i]);
      if (h[i] == 1) a = 1;
    end
    if (a && s + 10 <= 21) return s + 10;
    return s;
  endfunction

  task automatic model_step(input bit r, input bit d, input bit h, input bit s, input int c);
    bit valid;
    bit want;
    int pb, db;
    valid = (c >= 1 && c <= 13);
    if (!r) begin
      m_state = 0; m_slot = 0; m_pend = 0;
      p_hand.delete(); d_hand.delete();
      return;
    end
    case (m_state)
      0, 4, 5, 6, 7: if (d) begin
        p_hand.delete(); d_hand.delete();
        m_state = 1; m_slot = 0;
      end
      1: if (valid) begin
        if (m_slot % 2 == 0) p_hand.push_back(c);
        else d_hand.push_back(c);
        if (m_slot == 3) m_state = (best(p_hand) == 21) ? 3 : 2;
        m_slot = (m_slot + 1) % 4;
      end
      2: begin
        want = h || m_pend;
        m_pend = 0;
        if (s) m_state = 3;
        else if (want && p_hand.size() < MAXC) begin
          if (valid) begin
            p_hand.push_back(c);
            pb = best(p_hand);
            if (pb > 21) m_state = 7;
            else if (pb == 21) m_state = 3;
          end else m_pend = 1;
        end
      end
      3: begin
        db = best(d_hand);
        if (db < STAND && d_hand.size() < MAXC) begin
          if (valid) d_hand.push_back(c);
        end else begin
          pb = best(p_hand);
          if (db > 21 || pb > db) m_state = 4;
          else if (pb < db) m_state = 5;
          else m_state = 6;
        end
      end
      default: m_state = 0;
    endcase
  endtask

  // One clock: drive inputs, advance the model, compare all outputs after the edge.
  task automatic cyc(input bit r, input bit d, input bit h, input bit s, input int c);
    int prev, exp_ds;
    bit exp_show;
    prev = m_state;
    rst_n = r; deal_pressed = d; hit_pressed = h; stand_pressed = s;
    card_value = 4'(c);
    model_step(r, d, h, s, c);
    @(posedge clk);
    #1;
    exp_show = (m_state == 1 || m_state == 2);
    if (exp_show) exp_ds = (d_hand.size() == 0) ? 0 : ((d_hand[0] == 1) ? 11 : pts(d_hand[0]));
    else exp_ds = best(d_hand);
    check_val("game_state", game_state, m_state);
    check_val("player_score", player_score, best(p_hand));
    check_val("dealer_score", dealer_score, exp_ds);
    check_val("show_dealer_first", show_dealer_first, exp_show);
    check_val("player_cards", player_cards, p_hand.size());
    check_val("dealer_cards", dealer_cards, d_hand.size());
    if (m_state >= 4 && m_state != prev)
      $display("round end: state=%0d player=%0d dealer=%0d", m_state, best(p_hand), best(d_hand));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)));
      check_val("rst_game_state", game_state, 0);
      check_val("rst_show", show_dealer_first, 0);
    end
  endtask

  task automatic deal4(input int a, input int b, input int c, input int d);
    cyc(1, 1, 0, 0, 3);
    cyc(1, 0, 0, 0, a);
    cyc(1, 0, 0, 0, b);
    cyc(1, 0, 0, 0, c);
    cyc(1, 0, 0, 0, d);
  endtask

  initial begin
    int cv;
    do_reset(4);

    // Player blackjack: straight to dealer, dealer reaches 21 -> push.
    cyc(1, 1, 0, 0, 5);
    cyc(1, 0, 0, 0, 10);
    cyc(1, 0, 0, 0, 6);
    check_val("bj_hidden", dealer_score, 6);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 5);
    check_val("bj_state", game_state, 3);
    check_val("bj_player", player_score, 21);
    check_val("bj_dealer", dealer_score, 11);
    cyc(1, 0, 0, 0, 10);
    cyc(1, 0, 0, 0, 3);
    check_val("bj_push", game_state, 6);

    // Player bust, then redeal clears hands.
    do_reset(1);
    deal4(9, 10, 7, 7);
    check_val("bust_player_state", game_state, 2);
    check_val("bust_hidden", dealer_score, 10);
    cyc(1, 0, 1, 0, 8);
    check_val("bust_state", game_state, 7);
    check_val("bust_score", player_score, 24);
    cyc(1, 1, 0, 0, 3);
    check_val("redeal_state", game_state, 1);
    check_val("redeal_pcards", player_cards, 0);
    check_val("redeal_dcards", dealer_cards, 0);

    // Stand, dealer busts.
    do_reset(1);
    deal4(10, 10, 8, 6);
    cyc(1, 0, 0, 1, 4);
    check_val("stand_show", show_dealer_first, 0);
    check_val("stand_dealer", dealer_score, 16);
    cyc(1, 0, 0, 0, 9);
    check_val("dbust_score", dealer_score, 25);
    cyc(1, 0, 0, 0, 2);
    check_val("dbust_state", game_state, 4);

    // Invalid code stalls a deal slot; hit+stand together resolves as stand.
    do_reset(1);
    cyc(1, 1, 0, 0, 3);
    cyc(1, 0, 0, 0, 5);
    cyc(1, 0, 0, 0, 0);
    check_val("stall_dcards", dealer_cards, 0);
    check_val("stall_pcards", player_cards, 1);
    cyc(1, 0, 0, 0, 6);
    cyc(1, 0, 0, 0, 7);
    cyc(1, 0, 0, 0, 8);
    check_val("stall_state", game_state, 2);
    cyc(1, 0, 1, 1, 2);
    check_val("hitstand_state", game_state, 3);
    check_val("hitstand_pcards", player_cards, 2);

    // Full hand ignores hit.
    do_reset(1);
    deal4(1, 10, 1, 7);
    cyc(1, 0, 1, 0, 2);
    cyc(1, 0, 1, 0, 2);
    cyc(1, 0, 1, 0, 1);
    cyc(1, 0, 1, 0, 1);
    cyc(1, 0, 1, 0, 1);
    check_val("full_pcards", player_cards, 7);
    cyc(1, 0, 1, 0, 2);
    check_val("full_ignore_pcards", player_cards, 7);
    check_val("full_ignore_state", game_state, 2);
    check_val("full_score", player_score, 19);

    // Random play, including invalid codes and occasional mid-round resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) cv = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(14, 15));
      else cv = int'($urandom_range(1, 13));
      cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0), cv);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
